// File: rtl/uart_cmd_controller.sv
// Frame-level command controller: parses A5-framed read/write commands from the RX FIFO,
// updates a bank of 16-bit registers and queues ACK/NAK/read-data bytes into the TX FIFO.
module uart_cmd_controller #(
  parameter int          NUM_REGS       = 8,
  parameter logic [15:0] REG_RESET      = 16'h0000,
  parameter int          TIMEOUT_CYCLES = 270000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rx_empty,
  input  logic [7:0]              rx_data,
  output logic                    rx_remove,
  input  logic                    tx_full,
  output logic [7:0]              tx_data,
  output logic                    tx_insert,
  output logic [16*NUM_REGS-1:0]  reg_q,
  output logic [NUM_REGS-1:0]     reg_wr_strobe,
  output logic                    busy,
  output logic                    frame_error
);

  // state | meaning
  // HUNT  | discard bytes until sync 0xA5
  // CMD   | expect 0x57 (write) or 0x52 (read)
  // ADDR  | register address
  // DHI   | write data high byte
  // DLO   | write data low byte
  // CSUM  | XOR of all bytes after sync
  // EXEC  | validate frame, act on register bank, queue response
  // RESP  | push queued response bytes into TX FIFO
  localparam logic [2:0] S_HUNT = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_DHI  = 3'd3;
  localparam logic [2:0] S_DLO  = 3'd4;
  localparam logic [2:0] S_CSUM = 3'd5;
  localparam logic [2:0] S_EXEC = 3'd6;
  localparam logic [2:0] S_RESP = 3'd7;

  localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TOUT_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]    NUM_REGS_W = 9'(NUM_REGS);

  logic [2:0]             state_q, state_d;
  logic                   is_wr_q, is_wr_d;
  logic [7:0]             addr_q, addr_d;
  logic [7:0]             dhi_q, dhi_d;
  logic [7:0]             dlo_q, dlo_d;
  logic [7:0]             csum_q, csum_d;
  logic [TW-1:0]          tout_q, tout_d;
  logic [23:0]            resp_q, resp_d;
  logic [1:0]             resp_left_q, resp_left_d;
  logic [16*NUM_REGS-1:0] regs_q, regs_d;
  logic [15:0]            rd_val;
  logic                   addr_ok;

  assign addr_ok = {1'b0, addr_q} < NUM_REGS_W;

  always_comb begin
    rd_val = 16'h0000;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_q == 8'(i)) rd_val = regs_q[16*i +: 16];
    end
  end

  always_comb begin
    state_d       = state_q;
    is_wr_d       = is_wr_q;
    addr_d        = addr_q;
    dhi_d         = dhi_q;
    dlo_d         = dlo_q;
    csum_d        = csum_q;
    tout_d        = tout_q;
    resp_d        = resp_q;
    resp_left_d   = resp_left_q;
    regs_d        = regs_q;
    rx_remove     = 1'b0;
    tx_insert     = 1'b0;
    tx_data       = 8'h00;
    reg_wr_strobe = '0;
    frame_error   = 1'b0;

    if (state_q <= S_CSUM) rx_remove = ~rx_empty;

    // Inside a frame: running checksum over consumed bytes, inter-byte timeout otherwise.
    if (state_q != S_HUNT && state_q <= S_CSUM) begin
      if (rx_empty) begin
        tout_d = tout_q + TW'(1);
        if (tout_q == TOUT_LAST) begin
          frame_error = 1'b1;
          tout_d      = '0;
          state_d     = S_HUNT;
        end
      end else begin
        tout_d = '0;
        csum_d = csum_q ^ rx_data;
      end
    end

    case (state_q)
      S_HUNT: begin
        tout_d = '0;
        csum_d = 8'h00;
        if (!rx_empty && rx_data == 8'hA5) state_d = S_CMD;
      end
      S_CMD: begin
        if (!rx_empty) begin
          if (rx_data == 8'h57 || rx_data == 8'h52) begin
            is_wr_d = (rx_data == 8'h57);
            state_d = S_ADDR;
          end else begin
            frame_error = 1'b1;
            resp_d      = {8'h15, 16'h0000};
            resp_left_d = 2'd1;
            state_d     = S_RESP;
          end
        end
      end
      S_ADDR: begin
        if (!rx_empty) begin
          addr_d  = rx_data;
          state_d = is_wr_q ? S_DHI : S_CSUM;
        end
      end
      S_DHI: begin
        if (!rx_empty) begin
          dhi_d   = rx_data;
          state_d = S_DLO;
        end
      end
      S_DLO: begin
        if (!rx_empty) begin
          dlo_d   = rx_data;
          state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (!rx_empty) state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_RESP;
        if (csum_q != 8'h00 || !addr_ok) begin
          frame_error = 1'b1;
          resp_d      = {8'h15, 16'h0000};
          resp_left_d = 2'd1;
        end else if (is_wr_q) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == 8'(i)) begin
              regs_d[16*i +: 16] = {dhi_q, dlo_q};
              reg_wr_strobe[i]   = 1'b1;
            end
          end
          resp_d      = {8'h06, 16'h0000};
          resp_left_d = 2'd1;
        end else begin
          resp_d      = {rd_val, addr_q ^ rd_val[15:8] ^ rd_val[7:0]};
          resp_left_d = 2'd3;
        end
      end
      S_RESP: begin
        tx_data   = resp_q[23:16];
        tx_insert = ~tx_full;
        if (!tx_full) begin
          resp_d      = {resp_q[15:0], 8'h00};
          resp_left_d = resp_left_q - 2'd1;
          if (resp_left_q == 2'd1) state_d = S_HUNT;
        end
      end
      default: state_d = S_HUNT;
    endcase
  end

  assign reg_q = regs_q;
  assign busy  = (state_q != S_HUNT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_HUNT;
      is_wr_q     <= 1'b0;
      addr_q      <= 8'h00;
      dhi_q       <= 8'h00;
      dlo_q       <= 8'h00;
      csum_q      <= 8'h00;
      tout_q      <= '0;
      resp_q      <= 24'h000000;
      resp_left_q <= 2'd0;
      regs_q      <= {NUM_REGS{REG_RESET}};
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      addr_q      <= addr_d;
      dhi_q       <= dhi_d;
      dlo_q       <= dlo_d;
      csum_q      <= csum_d;
      tout_q      <= tout_d;
      resp_q      <= resp_d;
      resp_left_q <= resp_left_d;
      regs_q      <= regs_d;
    end
  end

endmodule
